jtframe_dwnld_prog: RTL
=======================

// Module: jtframe_dwnld_prog
// PURPOSE
//  Download programmer sitting between the MiST I/O-controller ROM loader and the SDRAM/PROM write ports.
//  Consumes the byte stream ioctl_addr/ioctl_data/ioctl_wr and translates each byte:
//   - CPU/GFX bytes become SDRAM byte-lane writes on prog_addr/prog_data/prog_mask/prog_we.
//   - PROM bytes become one-cycle on-chip PROM writes.
//  Buffers bytes in a small FIFO so back-to-back ioctl writes survive SDRAM write latency.
// PARAMETERS
//  GFX_START   22'h10_0000  first byte address of the GFX region (below it: CPU region)
//  GFX_OFFSET  22'h08_0000  SDRAM word address where the GFX region is placed
//  PROM_START  22'h3F_0000  first byte address of the PROM region (on-chip, not SDRAM)
//  PROM_AW     10           PROM address width
//  FIFO_AW     2            FIFO depth = 2**FIFO_AW entries of {addr[21:0],data[7:0]}
// PORTS
//  clk_rom      in   1   SDRAM/download clock; every flop is on this clock
//  rst_n        in   1   asynchronous, active-low reset
//  downloading  in   1   high while the I/O controller streams a ROM
//  ioctl_addr   in   22  byte address of the current download byte
//  ioctl_data   in   8   download byte
//  ioctl_wr     in   1   one-cycle strobe; ioctl_addr/ioctl_data are valid in that cycle
//  prog_addr    out  22  SDRAM 16-bit word address
//  prog_data    out  8   byte to write, driven on both SDRAM byte lanes
//  prog_mask    out  2   active-low byte mask: 2'b10 = low byte, 2'b01 = high byte
//  prog_we      out  1   SDRAM write request; held high until prog_rdy
//  prog_rdy     in   1   SDRAM controller accepted the write
//  prom_addr    out  PROM_AW  PROM address
//  prom_data    out  8   PROM data
//  prom_we      out  1   one-cycle PROM write strobe
//  busy         out  1   downloading | FIFO not empty | write outstanding; holds the game in reset
//  dwnld_done   out  1   one-cycle pulse once the last byte is committed after downloading falls
//  ovf          out  1   sticky: an ioctl_wr arrived with the FIFO full; cleared by a rising downloading
// BEHAVIOUR
//  Reset: every output is 0 and prog_mask = 2'b11; FIFO is empty; state is IDLE.
//  Push: ioctl_wr & ~full writes {ioctl_addr,ioctl_data} into the FIFO.
//   - ioctl_wr & full drops the byte and sets ovf.
//   - Push and pop in the same cycle is legal; count is unchanged.
//  Decode (at pop), with byte address a:
//   - a < GFX_START: CPU region, prog_addr = a>>1.
//   - GFX_START <= a < PROM_START: GFX region, prog_addr = ((a-GFX_START)>>1)+GFX_OFFSET.
//   - For both SDRAM regions: a[0]=0 -> prog_mask=2'b10; a[0]=1 -> prog_mask=2'b01.
//   - a >= PROM_START: prom_addr = a[PROM_AW-1:0].
//   - Subtraction is 22-bit unsigned; the sum wraps mod 2**22.
//  FSM states:
//   - IDLE: FIFO non-empty -> pop. SDRAM byte -> WRITE. PROM byte -> prom_we=1 for exactly 1 cycle, stay IDLE.
//   - IDLE: downloading falls (registered edge) -> DRAIN.
//   - WRITE: prog_we=1, prog_addr/data/mask stable. When prog_rdy=1: prog_we=0 next cycle, mask=2'b11, return to IDLE.
//   - WRITE: prog_rdy already high on entry still costs one full cycle of prog_we.
//   - DRAIN: keeps serving FIFO/WRITE exactly as IDLE does. When the FIFO is empty and no write is outstanding -> DONE.
//   - DONE: dwnld_done=1 for one cycle -> IDLE.
//   - downloading falling while in WRITE is latched and handled when WRITE completes.
//  Latency: ioctl_wr at cycle 0 into an empty FIFO -> prog_we or prom_we high at cycle 2.
//  Throughput: one byte per 2 cycles plus prog_rdy wait.
//  downloading rising: clears ovf. If a drain is in progress, it continues; dwnld_done still fires once the FIFO empties.
//  Asserting rst_n low mid-write drops prog_we at once and discards the FIFO contents.
//  busy is combinational from registered state: downloading | ~empty | (state != IDLE).
// STRUCTURE
//  Shared package jtframe_dwnld_pkg holds:
//   - FSM state encoding (IDLE, WRITE, DRAIN, DONE)
//   - region enum (CPU, GFX, PROM)
//   - the byte-mask constants MASK_LO=2'b10, MASK_HI=2'b01, MASK_NONE=2'b11.
//  Sub-module jtframe_dwnld_fifo: synchronous FIFO, 30-bit wide, 2**FIFO_AW deep.
//   - Ports: push, pop, din, dout, empty, full; first-word-fall-through.
//  Top level holds the region decode, the FSM and the ovf/done logic.
// TESTING
//  1. CPU bytes: ioctl writes at 0x000000=0xAA and 0x000001=0x55, prog_rdy 3 cycles after prog_we.
//     -> Two writes: (addr 0, data 0xAA, mask 2'b10) then (addr 0, data 0x55, mask 2'b01). Each prog_we drops the cycle after prog_rdy.
//  2. GFX offset: byte at 0x100003 = 0x12.
//     -> prog_addr=0x080001, mask 2'b01, data 0x12.
//  3. PROM: byte at 0x3F0105 = 0x7C.
//     -> prom_we is high for exactly 1 cycle with prom_addr=0x105, data 0x7C. prog_we stays 0.
//  4. Overflow: prog_rdy held low, 6 ioctl_wr strobes on consecutive cycles with FIFO_AW=2.
//     -> 4 bytes stored, the 1 popped into WRITE occupies no FIFO slot, ovf=1.
//     -> Releasing prog_rdy delivers the stored bytes in order.
//  5. Drain: downloading falls with 3 bytes queued.
//     -> busy stays high until the 3rd write is acked. dwnld_done pulses 1 cycle later, then busy=0.
//  6. Reset mid-write: rst_n low during WRITE.
//     -> prog_we=0 and prog_mask=2'b11 immediately. After release: busy=0, FIFO empty, no dwnld_done.

Source files
------------

// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg: shared FSM encoding, region decode and byte-mask constants for the download programmer
package jtframe_dwnld_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {CPU, GFX, PROM} region_t;
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;
    localparam int ENTRY_W = 30;
    function automatic region_t region_of(input logic [21:0] a, input logic [21:0] gfx_start,
                                          input logic [21:0] prom_start);
        return a >= prom_start ? PROM : a >= gfx_start ? GFX : CPU;
    endfunction
endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// jtframe_dwnld_fifo: first-word-fall-through FIFO of {addr,data} download entries
module jtframe_dwnld_fifo
    import jtframe_dwnld_pkg::*;
#(
    parameter int AW = 2,
    parameter int DW = ENTRY_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);
    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr, rd_ptr;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/jtframe_dwnld_prog.sv
// jtframe_dwnld_prog: turns the ioctl download byte stream into SDRAM byte-lane writes and on-chip PROM writes
module jtframe_dwnld_prog
    import jtframe_dwnld_pkg::*;
#(
    parameter logic [21:0] GFX_START  = 22'h10_0000,
    parameter logic [21:0] GFX_OFFSET = 22'h08_0000,
    parameter logic [21:0] PROM_START = 22'h3F_0000,
    parameter int          PROM_AW    = 10,
    parameter int          FIFO_AW    = 2
) (
    input  logic               clk_rom,
    input  logic               rst_n,
    input  logic               downloading,
    input  logic [21:0]        ioctl_addr,
    input  logic [7:0]         ioctl_data,
    input  logic               ioctl_wr,
    output logic [21:0]        prog_addr,
    output logic [7:0]         prog_data,
    output logic [1:0]         prog_mask,
    output logic               prog_we,
    input  logic               prog_rdy,
    output logic [PROM_AW-1:0] prom_addr,
    output logic [7:0]         prom_data,
    output logic               prom_we,
    output logic               busy,
    output logic               dwnld_done,
    output logic               ovf
);
    logic [ENTRY_W-1:0] fifo_dout;
    logic               empty, full, pop;
    logic [21:0]        a, sdram_addr;
    logic [7:0]         d;
    logic [1:0]         mask_r;
    logic               dl_r, drain_r, fall, rise, drain, is_prom;
    region_t            region;
    state_t             state, next_state;

    jtframe_dwnld_fifo #(.AW(FIFO_AW), .DW(ENTRY_W)) u_fifo (
        .clk   (clk_rom),
        .rst_n (rst_n),
        .push  (ioctl_wr),
        .pop   (pop),
        .din   ({ioctl_addr, ioctl_data}),
        .dout  (fifo_dout),
        .empty (empty),
        .full  (full)
    );

    assign {a, d}     = fifo_dout;
    assign region     = region_of(a, GFX_START, PROM_START);
    assign is_prom    = region == PROM;
    assign sdram_addr = region == GFX ? ((a - GFX_START) >> 1) + GFX_OFFSET : a >> 1;
    assign fall       = dl_r & ~downloading;
    assign rise       = downloading & ~dl_r;
    // a fall seen this very cycle counts as a pending drain
    assign drain      = drain_r | fall;
    assign pop        = (state == IDLE || state == DRAIN) && !empty;

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:  next_state = !empty ? (!is_prom ? WRITE : drain ? DRAIN : IDLE) : drain ? DRAIN : IDLE;
            DRAIN: next_state = !empty ? (!is_prom ? WRITE : DRAIN) : DONE;
            WRITE: next_state = !prog_rdy ? WRITE : !drain ? IDLE : empty ? DONE : DRAIN;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        prog_we    = state == WRITE;
        prog_mask  = prog_we ? mask_r : MASK_NONE;
        dwnld_done = state == DONE;
        busy       = downloading | ~empty | (state != IDLE);
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            prog_addr <= '0;
            prog_data <= '0;
            mask_r    <= MASK_NONE;
            prom_addr <= '0;
            prom_data <= '0;
            prom_we   <= 1'b0;
            ovf       <= 1'b0;
            dl_r      <= 1'b0;
            drain_r   <= 1'b0;
        end else begin
            dl_r    <= downloading;
            drain_r <= fall | (drain_r & (state != DONE));
            ovf     <= (ioctl_wr & full) | (ovf & ~rise);
            prom_we <= pop & is_prom;
            if (pop && !is_prom) begin
                prog_addr <= sdram_addr;
                prog_data <= d;
                mask_r    <= a[0] ? MASK_HI : MASK_LO;
            end
            if (pop && is_prom) begin
                prom_addr <= a[PROM_AW-1:0];
                prom_data <= d;
            end
        end
    end
endmodule
